// File: rtl/mul_32x32.sv
// mul_32x32: pipelined 32x32 unsigned multiplier with carry-save reduction and a 3-edge latency
module mul_32x32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [63:0] s,
  output logic        cout,
  input  logic        clk,
  output logic        cout1,
  input  logic        rst_n
);
  logic [31:0]       x_q, y_q;
  logic [31:0][63:0] pp;
  logic [7:0][63:0]  rows_d, rows_q;
  logic [1:0][63:0]  red_d;
  logic [63:0]       sum_q, carry_q;
  logic [63:0]       s_d, s_q;
  logic              cout_d, cout_q, cout1_d, cout1_q;

  // 3:2 compressor; the shifted carry drops bit 63, which never carries weight for in-range products
  function automatic logic [1:0][63:0] csa(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    logic [63:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    csa = {{maj[62:0], 1'b0}, a ^ b ^ c};
  endfunction

  // eight rows down to a sum/carry pair through four compressor levels
  function automatic logic [1:0][63:0] reduce8(input logic [7:0][63:0] r);
    logic [1:0][63:0] ab, cd, ef, gh, ij, kl;
    ab = csa(r[0], r[1], r[2]);
    cd = csa(r[3], r[4], r[5]);
    ef = csa(ab[0], ab[1], cd[0]);
    gh = csa(cd[1], r[6], r[7]);
    ij = csa(ef[0], ef[1], gh[0]);
    kl = csa(ij[0], ij[1], gh[1]);
    reduce8 = kl;
  endfunction

  // partial products from the captured operands, each group of eight compressed to two rows
  always_comb begin
    for (int i = 0; i < 32; i++) pp[i] = {32'b0, x_q & {32{y_q[i]}}} << i;
    for (int g = 0; g < 4; g++) rows_d[2*g +: 2] = reduce8(pp[8*g +: 8]);
  end

  // second compression stage and final carry-propagate add with overflow detection
  always_comb begin
    red_d = reduce8(rows_q);
    {cout_d, s_d} = {1'b0, sum_q} + {1'b0, carry_q};
    cout1_d = |s_d[63:32];
  end

  // pipeline registers: operand capture, row stage, sum/carry stage, result stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      rows_q  <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      cout1_q <= 1'b0;
    end else begin
      x_q     <= x;
      y_q     <= y;
      rows_q  <= rows_d;
      sum_q   <= red_d[0];
      carry_q <= red_d[1];
      s_q     <= s_d;
      cout_q  <= cout_d;
      cout1_q <= cout1_d;
    end
  end

  assign s     = s_q;
  assign cout  = cout_q;
  assign cout1 = cout1_q;
endmodule

// File: tb/tb_mul_32x32.sv
// tb_mul_32x32: table-driven and random checks of the multiplier through a latency-3 scoreboard
module tb_mul_32x32;
  logic [31:0] x, y;
  logic [63:0] s;
  logic        cout, cout1, clk, rst_n;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] es;
    logic        ec1;
  } vec_t;

  typedef struct {
    logic [63:0] es;
    logic        ec1;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  mul_32x32 dut (.x(x), .y(y), .s(s), .cout(cout), .clk(clk), .cout1(cout1), .rst_n(rst_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [63:0] es, input logic ec1);
    exp_t e;
    x = a;
    y = b;
    sb.push_back('{es, ec1});
    @(posedge clk);
    #1;
    if (sb.size() > 3) begin
      e = sb.pop_front();
      chk("s", s, e.es);
      chk("cout", {63'b0, cout}, 64'd0);
      chk("cout1", {63'b0, cout1}, {63'b0, e.ec1});
    end
  endtask

  task automatic prefill();
    sb.delete();
    repeat (3) sb.push_back('{64'd0, 1'b0});
  endtask

  initial begin
    logic [31:0] a, b;
    logic [63:0] p;
    vec_t v;
    vecs.push_back('{32'd0,   32'd1111,   64'd0,        1'b0});
    vecs.push_back('{32'd10,  32'd11111,  64'd111110,   1'b0});
    vecs.push_back('{32'd111, 32'd111,    64'd12321,    1'b0});
    vecs.push_back('{32'd22,  32'd22,     64'd484,      1'b0});
    vecs.push_back('{32'd100, 32'd505000, 64'd50500000, 1'b0});
    for (int k = 5; k <= 31; k++)
      if (k <= 16 || k >= 28) vecs.push_back('{32'd1 << k, 32'd63, 64'd63 << k, k >= 27});
    vecs.push_back('{32'd1111111111, 32'd1111111111, 64'd1234567900987654321, 1'b1});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1});
    rst_n = 1'b0;
    x = '0;
    y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s", s, 64'd0);
    chk("rst_cout", {63'b0, cout}, 64'd0);
    chk("rst_cout1", {63'b0, cout1}, 64'd0);
    rst_n = 1'b1;
    prefill();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step(v.a, v.b, v.es, v.ec1);
    end
    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      b = $urandom;
      p = {32'b0, a} * {32'b0, b};
      step(a, b, p, |p[63:32]);
    end
    repeat (4) step(32'hFFFFFFFF, 32'd7, 64'h6FFFFFFF9, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_s", s, 64'd0);
    chk("async_cout1", {63'b0, cout1}, 64'd0);
    @(posedge clk);
    #1;
    chk("hold_s", s, 64'd0);
    #2;
    rst_n = 1'b1;
    prefill();
    step(32'd0, 32'd1111, 64'd0, 1'b0);
    step(32'd10, 32'd11111, 64'd111110, 1'b0);
    step(32'd111, 32'd111, 64'd12321, 1'b0);
    step(32'd22, 32'd22, 64'd484, 1'b0);
    step(32'd100, 32'd505000, 64'd50500000, 1'b0);
    repeat (3) step(32'd0, 32'd0, 64'd0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
